// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall/flush sequencer for a 5-stage RV32I pipeline. Drives the
//   hold/flush controls of the PC, IF_ID, ID_EX and EX_MEM registers from three
//   events: load-use hazards, taken-branch redirects (flush window of
//   BR_PENALTY cycles) and data-memory wait states (guarded by a TIMEOUT
//   watchdog).
//
//   Handshake note: there is no valid/ready pair here; every cycle is a
//   decision. Control outputs are combinational from the registered state and
//   the current inputs, so they take effect at the next rising edge of clk.
//
// Parameters:
//   BR_PENALTY  cycles if_id_flush stays asserted after a taken branch (1..3)
//   TIMEOUT     max consecutive MEM_WAIT cycles before forced release
//   TW          width of the timeout counter (must hold TIMEOUT)
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   if_id_rs1/rs2, rs1_used/rs2_used   source operands of the ID instruction
//   id_ex_rd, id_ex_mem_read  destination / load flag of the EX instruction
//   ex_branch_taken           one-cycle pulse per taken branch/jump in EX
//   mem_busy                  data memory not ready
//   pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall
//   timeout_err               sticky MEM_WAIT timeout flag
//   state_o                   FSM state: 00 RUN, 01 MEM_WAIT, 10 REDIRECT
//
// Optional feature (macro PIPE_PERF_CNT_EN):
//   adds stall_cycles / flush_cycles 32-bit wrapping counters of the cycles
//   with pc_stall=1 and if_id_flush=1 respectively.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int BR_PENALTY = 1,
    parameter int TIMEOUT    = 255,
    parameter int TW         = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  if_id_rs1,
    input  logic [4:0]  if_id_rs2,
    input  logic        rs1_used,
    input  logic        rs2_used,
    input  logic [4:0]  id_ex_rd,
    input  logic        id_ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        mem_busy,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_flush,
    output logic        ex_mem_stall,
    output logic        timeout_err,
    output logic [1:0]  state_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_REDIRECT = 2'b10
    } state_t;

    localparam logic [1:0]    BR_LOAD = 2'(BR_PENALTY - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
    // With a one-cycle penalty the flush happens entirely in the RUN cycle.
    localparam state_t        ST_AFTER_BR = (BR_PENALTY > 1) ? ST_REDIRECT : ST_RUN;

    state_t        r_state;
    state_t        w_next_state;
    logic [1:0]    r_flush_cnt;
    logic [1:0]    w_flush_cnt_nxt;
    logic [TW-1:0] r_to_cnt;
    logic [TW-1:0] w_to_cnt_nxt;
    logic          r_timeout_err;
    logic          w_timeout_set;
    logic          w_load_use;
    logic          w_to_hit;

    assign w_load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                        ((rs1_used && (id_ex_rd == if_id_rs1)) ||
                         (rs2_used && (id_ex_rd == if_id_rs2)));
    assign w_to_hit   = (r_to_cnt == TO_MAX);

    // State register (with counters and the sticky error flag)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_RUN;
            r_flush_cnt   <= 2'd0;
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_flush_cnt   <= w_flush_cnt_nxt;
            r_to_cnt      <= w_to_cnt_nxt;
            r_timeout_err <= r_timeout_err | w_timeout_set;
        end
    end

    // Next-state and counter update
    always_comb begin
        w_next_state    = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_to_cnt_nxt    = r_to_cnt;
        w_timeout_set   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (mem_busy) begin
                    w_next_state = ST_MEM_WAIT;
                    w_to_cnt_nxt = TW'(1);
                end else if (ex_branch_taken) begin
                    w_next_state    = ST_AFTER_BR;
                    w_flush_cnt_nxt = BR_LOAD;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_busy) begin
                    w_next_state = ST_RUN;
                    w_to_cnt_nxt = '0;
                end else if (w_to_hit) begin
                    // Forced release; a still-busy memory re-enters from RUN.
                    w_next_state  = ST_RUN;
                    w_to_cnt_nxt  = '0;
                    w_timeout_set = 1'b1;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TW'(1);
                end
            end
            ST_REDIRECT: begin
                if (mem_busy) begin
                    w_next_state    = ST_MEM_WAIT;
                    w_flush_cnt_nxt = 2'd0;
                    w_to_cnt_nxt    = TW'(1);
                end else if (ex_branch_taken) begin
                    w_next_state    = ST_AFTER_BR;
                    w_flush_cnt_nxt = BR_LOAD;
                end else begin
                    if (r_flush_cnt != 2'd0) begin
                        w_flush_cnt_nxt = r_flush_cnt - 2'd1;
                    end
                    // Last flush cycle is the one that sees the count at 1.
                    if (r_flush_cnt <= 2'd1) begin
                        w_next_state = ST_RUN;
                    end
                end
            end
            default: begin
                w_next_state    = ST_RUN;
                w_flush_cnt_nxt = 2'd0;
                w_to_cnt_nxt    = '0;
            end
        endcase
    end

    // Control outputs; stall and flush of the same register are exclusive.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (mem_busy) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                end else if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (w_load_use) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_busy && !w_to_hit) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                end
            end
            ST_REDIRECT: begin
                if (mem_busy) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                end else if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else begin
                    if_id_flush = (r_flush_cnt != 2'd0);
                end
            end
            default: begin
            end
        endcase
    end

    assign timeout_err = r_timeout_err;
    assign state_o     = r_state;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_cycles;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= 32'd0;
            r_flush_cycles <= 32'd0;
        end else begin
            if (pc_stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (if_id_flush) begin
                r_flush_cycles <= r_flush_cycles + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_cycles = r_flush_cycles;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl with BR_PENALTY=3, TIMEOUT=8.
//   The driver applies one input vector per cycle just after the rising edge
//   and queues the hand-computed expected outputs; the monitor pops one entry
//   per falling edge and compares. Observed vector layout:
//   {state_o[1:0], timeout_err, pc_stall, if_id_stall, if_id_flush,
//    id_ex_stall, id_ex_flush, ex_mem_stall}
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int W = 9;

    // Control field {pc, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall}
    localparam logic [5:0] C_Z   = 6'b000000;
    localparam logic [5:0] C_ST4 = 6'b110101;
    localparam logic [5:0] C_BR  = 6'b001010;
    localparam logic [5:0] C_IFF = 6'b001000;
    localparam logic [5:0] C_LU  = 6'b110010;

    localparam logic [1:0] S_RUN = 2'b00;
    localparam logic [1:0] S_MW  = 2'b01;
    localparam logic [1:0] S_RD  = 2'b10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] if_id_rs1 = '0;
    logic [4:0] if_id_rs2 = '0;
    logic       rs1_used = 1'b0;
    logic       rs2_used = 1'b0;
    logic [4:0] id_ex_rd = '0;
    logic       id_ex_mem_read = 1'b0;
    logic       ex_branch_taken = 1'b0;
    logic       mem_busy = 1'b0;
    logic       pc_stall, if_id_stall, if_id_flush;
    logic       id_ex_stall, id_ex_flush, ex_mem_stall;
    logic       timeout_err;
    logic [1:0] state_o;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_cycles;
`endif

    pipe_hazard_ctrl #(
        .BR_PENALTY(3),
        .TIMEOUT   (8),
        .TW        (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_id_rs1      (if_id_rs1),
        .if_id_rs2      (if_id_rs2),
        .rs1_used       (rs1_used),
        .rs2_used       (rs2_used),
        .id_ex_rd       (id_ex_rd),
        .id_ex_mem_read (id_ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mem_busy       (mem_busy),
        .pc_stall       (pc_stall),
        .if_id_stall    (if_id_stall),
        .if_id_flush    (if_id_flush),
        .id_ex_stall    (id_ex_stall),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_stall   (ex_mem_stall),
        .timeout_err    (timeout_err),
        .state_o        (state_o)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_cycles   (flush_cycles)
`endif
    );

    logic [W-1:0] obs;
    assign obs = {state_o, timeout_err, pc_stall, if_id_stall, if_id_flush,
                  id_ex_stall, id_ex_flush, ex_mem_stall};

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_checks = 0;
    int           n_errors = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            string        nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL %s: got %b expected %b (t=%0t)", nm, obs, e, $time);
            end
        end
    end

    task automatic check_now(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic busy, input logic br, input logic mr,
                        input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2,
                        input logic [1:0] st, input logic err, input logic [5:0] ctl,
                        input string nm);
        @(posedge clk);
        #1;
        mem_busy        = busy;
        ex_branch_taken = br;
        id_ex_mem_read  = mr;
        id_ex_rd        = rd;
        if_id_rs1       = r1;
        if_id_rs2       = r2;
        rs1_used        = u1;
        rs2_used        = u2;
        exp_q.push_back({st, err, ctl});
        name_q.push_back(nm);
    endtask

    task automatic idle(input logic [1:0] st, input logic err, input logic [5:0] ctl, input string nm);
        step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, st, err, ctl, nm);
    endtask

    task automatic br_step(input logic [1:0] st, input logic [5:0] ctl, input string nm);
        step(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, st, 1'b0, ctl, nm);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        #2;
        check_now("reset_outputs", 32'(obs), 32'd0);
`ifdef PIPE_PERF_CNT_EN
        check_now("reset_stall_cycles", stall_cycles, 32'd0);
        check_now("reset_flush_cycles", flush_cycles, 32'd0);
`endif
        #10 rst = 1'b1;

        // Load-use via rs2, then the bubble clears id_ex_mem_read
        step(1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, S_RUN, 1'b0, C_LU, "lu_rs2");
        idle(S_RUN, 1'b0, C_Z, "lu_rs2_after");
        // rd = x0 never hazards; unused source never hazards
        step(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, S_RUN, 1'b0, C_Z, "lu_rd_x0");
        step(1'b0, 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, S_RUN, 1'b0, C_Z, "lu_rs1_unused");
        // Load-use via rs1; non-load with matching rd does not stall
        step(1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd1, 1'b1, 1'b0, S_RUN, 1'b0, C_LU, "lu_rs1");
        step(1'b0, 1'b0, 1'b0, 5'd7, 5'd7, 5'd1, 1'b1, 1'b0, S_RUN, 1'b0, C_Z, "no_load_match");

        // Branch with a 3-cycle flush window: state 00,10,10,00
        br_step(S_RUN, C_BR, "br_c0");
        idle(S_RD,  1'b0, C_IFF, "br_c1");
        idle(S_RD,  1'b0, C_IFF, "br_c2");
        idle(S_RUN, 1'b0, C_Z,   "br_c3");

        // Second branch inside the window reloads it
        br_step(S_RUN, C_BR, "rl_c0");
        idle(S_RD, 1'b0, C_IFF, "rl_c1");
        br_step(S_RD, C_BR, "rl_reload");
        idle(S_RD,  1'b0, C_IFF, "rl_c3");
        idle(S_RD,  1'b0, C_IFF, "rl_c4");
        idle(S_RUN, 1'b0, C_Z,   "rl_c5");

        // mem_busy during REDIRECT takes priority, window abandoned
        br_step(S_RUN, C_BR, "rb_c0");
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, S_RD, 1'b0, C_ST4, "rb_busy");
        idle(S_MW,  1'b0, C_Z, "rb_release");
        idle(S_RUN, 1'b0, C_Z, "rb_run");

        // Memory wait of 4 cycles with a branch pending from cycle 0
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0,
                 (i == 0) ? S_RUN : S_MW, 1'b0, C_ST4, $sformatf("mw_busy%0d", i));
        end
        br_step(S_MW,  C_Z,  "mw_release");
        br_step(S_RUN, C_BR, "mw_branch");
        idle(S_RD,  1'b0, C_IFF, "mw_br_c1");
        idle(S_RD,  1'b0, C_IFF, "mw_br_c2");
        idle(S_RUN, 1'b0, C_Z,   "mw_br_c3");

        // Timeout: 8 stalled cycles, one released cycle, then re-entry
        for (int i = 0; i < 20; i++) begin
            int p;
            p = i % 9;
            step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0,
                 (p == 0) ? S_RUN : S_MW, (i >= 9), (p == 8) ? C_Z : C_ST4,
                 $sformatf("to_%0d", i));
        end
        idle(S_MW,  1'b1, C_Z, "to_release");
        idle(S_RUN, 1'b1, C_Z, "to_sticky");

        // Asynchronous reset in the middle of a REDIRECT window
        step(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, S_RUN, 1'b1, C_BR, "ar_br");
        idle(S_RD, 1'b1, C_IFF, "ar_redirect");
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_now("async_reset_outputs", 32'(obs), 32'd0);
`ifdef PIPE_PERF_CNT_EN
        check_now("async_reset_stall_cycles", stall_cycles, 32'd0);
        check_now("async_reset_flush_cycles", flush_cycles, 32'd0);
`endif
        @(posedge clk);
        #2 rst = 1'b1;
        idle(S_RUN, 1'b0, C_Z, "post_reset_idle");
        step(1'b0, 1'b0, 1'b1, 5'd4, 5'd1, 5'd4, 1'b1, 1'b0, S_RUN, 1'b0, C_Z, "lu_rs2_unused");
        step(1'b0, 1'b0, 1'b1, 5'd4, 5'd1, 5'd4, 1'b1, 1'b1, S_RUN, 1'b0, C_LU, "lu_post_reset");
        idle(S_RUN, 1'b0, C_Z, "final_idle");

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
